// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared state encoding and default width for the serial adder
package serial_adder_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int DEF_WIDTH = 8;
endpackage

// File: rtl/serial_adder_8_full_adder.sv
// full_adder: single-bit full adder cell used by the serial datapath
module full_adder (
  output logic sum,
  output logic cout,
  input  logic a,
  input  logic b,
  input  logic cin
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_adder_8.sv
// serial_adder_8: bit-serial adder computing {carry,sum} = a + b + c_in one bit per clock, LSB first
module serial_adder_8
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);
  localparam int CW = $clog2(WIDTH);
  state_t state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr, res_nxt;
  logic [CW-1:0] cnt;
  logic cy, s_bit, cout, last;
  full_adder u_fa (.sum(s_bit), .cout(cout), .a(a_sr[0]), .b(b_sr[0]), .cin(cy));
  assign last    = cnt == CW'(WIDTH - 1);
  assign res_nxt = {s_bit, res_sr[WIDTH-1:1]};
  assign busy    = state != IDLE;
  assign done    = state == DONE;
  always_comb begin
    state_nxt = state;
    state_nxt = state == IDLE ? (start ? RUN : IDLE) :
                state == RUN  ? (last ? DONE : RUN) : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      cy     <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      carry  <= 1'b0;
    end else if (state == IDLE && start) begin
      a_sr <= a;
      b_sr <= b;
      cy   <= c_in;
      cnt  <= '0;
    end else if (state == RUN) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      res_sr <= res_nxt;
      cy     <= cout;
      cnt    <= cnt + CW'(1);
      if (last) begin
        sum   <= res_nxt;
        carry <= cout;
      end
    end
  end
endmodule

// File: tb/tb_serial_adder_8.sv
// tb_serial_adder_8: directed self-checking bench with a timestamp-based reference model
module tb_serial_adder_8;
  localparam int W = 8;
  localparam int N = W + 1;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, c_in = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic busy, done, carry;
  logic [W-1:0] sum;
  int tests = 0, fails = 0, dcnt = 0;
  int cyc = 0, acc = -100;
  logic was_idle;
  logic [N-1:0] pend = '0, res = '0;

  always #5 clk = ~clk;

  serial_adder_8 #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .c_in(c_in),
    .busy(busy), .done(done), .sum(sum), .carry(carry)
  );

  task automatic chk(input string n, input logic [N-1:0] act, input logic [N-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", n, act, exp, $time);
    end
  endtask

  // acc = edge count at the accepting edge; busy spans edges 0..W after it, result lands at W
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc = -100;
      res = '0;
    end else begin
      was_idle = (cyc - acc) > W;
      cyc++;
      if (was_idle && start) begin
        acc  = cyc;
        pend = {1'b0, a} + {1'b0, b} + N'(c_in);
      end
      if (cyc - acc == W) res = pend;
    end
  end

  always @(posedge clk) if (done) dcnt++;

  always @(negedge clk) begin
    int e;
    e = cyc - acc;
    chk("busy", N'(busy), N'(e >= 0 && e <= W));
    chk("done", N'(done), N'(e == W));
    chk("result", {carry, sum}, res);
  end

  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci, input logic [N-1:0] exp);
    int lat;
    @(negedge clk);
    a = x; b = y; c_in = ci; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", N'(lat), N'(W));
    chk("sum_lit", {carry, sum}, exp);
    chk("model_lit", res, exp);
    @(negedge clk);
  endtask

  initial begin
    int d0, nd, last;
    repeat (3) @(negedge clk);
    chk("rst_busy", N'(busy), '0);
    chk("rst_done", N'(done), '0);
    chk("rst_res", {carry, sum}, '0);
    rst_n = 1'b1;
    run_op(8'h25, 8'h3A, 1'b0, 9'h05F);
    run_op(8'hFF, 8'h01, 1'b0, 9'h100);
    run_op(8'hFF, 8'hFF, 1'b1, 9'h1FF);
    run_op(8'h00, 8'h00, 1'b1, 9'h001);
    repeat (5) @(negedge clk);
    chk("hold", {carry, sum}, 9'h001);
    run_op(8'h00, 8'h00, 1'b0, 9'h000);
    d0 = dcnt;
    @(negedge clk);
    a = 8'h10; b = 8'h20; c_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1; a = 8'hAA; b = 8'h55;
    repeat (3) begin
      @(negedge clk);
      a = ~a; b = ~b; c_in = ~c_in;
    end
    start = 1'b0;
    repeat (15) @(negedge clk);
    chk("one_done", N'(dcnt - d0), N'(1));
    chk("ign_res", {carry, sum}, 9'h030);
    @(negedge clk);
    a = 8'h7F; b = 8'h01; c_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", N'(busy), '0);
    chk("arst_done", N'(done), '0);
    chk("arst_res", {carry, sum}, '0);
    d0 = dcnt;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    chk("no_done", N'(dcnt - d0), '0);
    run_op(8'h7F, 8'h01, 1'b0, 9'h080);
    nd = 0;
    last = -1;
    @(negedge clk);
    a = 8'h01; b = 8'h01; c_in = 1'b0; start = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (done) begin
        chk("held_sum", {carry, sum}, 9'h002);
        if (last >= 0) chk("period", N'(i - last), N'(W + 2));
        last = i;
        nd++;
      end
    end
    start = 1'b0;
    chk("held_cnt", N'(nd), N'(4));
    repeat (12) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
